// File: rtl/stoch_pkg.sv
// Shared definitions for signed-channel stochastic blocks: ternary per-sample
// contribution type, (p, m) -> contribution mapping and output register states.
package stoch_pkg;

    typedef logic signed [1:0] stoch_diff_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // (1,1) and (0,0) cancel to zero.
    function automatic stoch_diff_t stoch_diff(input logic p, input logic m);
        stoch_diff_t d;
        case ({p, m})
            2'b10:   d = 2'sb01;
            2'b01:   d = 2'sb11;
            default: d = 2'sb00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stoch_window_counter.sv
// Sample counter for fixed 2^WINDOW_LOG2 windows; wraps N-1 -> 0 and flags the
// last sample position of the window.
module stoch_window_counter #(
    parameter int unsigned WINDOW_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   en,
    input  logic                   clear,
    output logic [WINDOW_LOG2-1:0] cnt,
    output logic                   last
);

    logic [WINDOW_LOG2-1:0] cnt_q;
    logic [WINDOW_LOG2-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == '1);

endmodule

// File: rtl/stoch_signed_decode.sv
// Signed stochastic decoder: sums (a_p - a_m) over windows of 2^WINDOW_LOG2
// enabled samples and presents each window sum through a valid/ready register.
module stoch_signed_decode
    import stoch_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 8
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          a_p,
    input  logic                          a_m,
    output logic signed [WINDOW_LOG2+1:0] y,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic                          overrun
);

    localparam int unsigned AW = WINDOW_LOG2 + 2;

    logic [WINDOW_LOG2-1:0] cnt;
    logic                   last;

    stoch_window_counter #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (en),
        .clear(clear),
        .cnt  (cnt),
        .last (last)
    );

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] y_q, y_d;
    logic                 ovr_q, ovr_d;
    out_state_t           state_q, state_d;

    stoch_diff_t          diff;
    logic signed [AW-1:0] sum;
    logic                 win_end;

    always_comb begin
        diff    = stoch_diff(a_p, a_m);
        sum     = acc_q + {{WINDOW_LOG2{diff[1]}}, diff};
        win_end = en && !clear && last;

        acc_d   = acc_q;
        y_d     = y_q;
        ovr_d   = ovr_q;
        state_d = state_q;

        if (clear) begin
            acc_d = '0;
            ovr_d = 1'b0;
        end else if (en) begin
            if (last) begin
                acc_d = '0;
                y_d   = sum;
            end else begin
                acc_d = sum;
            end
        end

        // A window end always lands in FULL; only a lost unconsumed result flags overrun.
        case (state_q)
            OUT_EMPTY: begin
                if (win_end) state_d = OUT_FULL;
            end
            OUT_FULL: begin
                if (win_end) begin
                    if (!y_ready) ovr_d = 1'b1;
                end else if (y_ready) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_q   <= '0;
            y_q     <= '0;
            ovr_q   <= 1'b0;
            state_q <= OUT_EMPTY;
        end else begin
            acc_q   <= acc_d;
            y_q     <= y_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign y       = y_q;
    assign y_valid = (state_q == OUT_FULL);
    assign overrun = ovr_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Directed bench for stoch_signed_decode with WINDOW_LOG2=3 (8-sample windows).
module tb_stoch_signed_decode;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       a_p = 1'b0;
    logic       a_m = 1'b0;
    logic       y_ready = 1'b0;
    logic [4:0] y;
    logic       y_valid;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    stoch_signed_decode #(
        .WINDOW_LOG2(3)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .en     (en),
        .clear  (clear),
        .a_p    (a_p),
        .a_m    (a_m),
        .y      (y),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic e, input logic p, input logic m,
                        input logic r, input logic c);
        en = e; a_p = p; a_m = m; y_ready = r; clear = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (y !== 5'd0 || y_valid !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: y=%b valid=%b ovr=%b, want 00000/0/0", y, y_valid, overrun);
        end
        nRST = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_plus;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL plus_early: valid=%b after 7 samples, want 0", y_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd8) begin
            n_bad++;
            $display("FAIL plus_result: y=%0d valid=%b, want 8/1", $signed(y), y_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0 || y !== 5'd8) begin
            n_bad++;
            $display("FAIL plus_consume: y=%0d valid=%b, want 8/0", $signed(y), y_valid);
        end
    endtask

    task automatic test_minus_zero;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'b11000) begin
            n_bad++;
            $display("FAIL minus_result: y=%0d valid=%b, want -8/1", $signed(y), y_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd0) begin
            n_bad++;
            $display("FAIL zero_result: y=%0d valid=%b, want 0/1", $signed(y), y_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_en_gaps;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL gaps_early: valid=%b after 7 enabled samples, want 0", y_valid);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd4) begin
            n_bad++;
            $display("FAIL gaps_result: y=%0d valid=%b, want 4/1", $signed(y), y_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd8 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_first: y=%0d valid=%b ovr=%b, want 8/1/0", $signed(y), y_valid, overrun);
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'b11110 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_second: y=%0d valid=%b ovr=%b, want -2/1/1", $signed(y), y_valid, overrun);
        end
        // partial window, then clear with an enabled sample that must be discarded
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'b11110 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_clear: y=%0d valid=%b ovr=%b, want -2/1/0", $signed(y), y_valid, overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0 || y !== 5'b11110) begin
            n_bad++;
            $display("FAIL ovr_consume: y=%0d valid=%b, want -2/0", $signed(y), y_valid);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_early: valid=%b after 7 samples post-clear, want 0", y_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd8) begin
            n_bad++;
            $display("FAIL b2b_first: y=%0d valid=%b, want 8/1", $signed(y), y_valid);
        end
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd8) begin
            n_bad++;
            $display("FAIL b2b_hold: y=%0d valid=%b, want 8/1", $signed(y), y_valid);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'b11000 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_coincident: y=%0d valid=%b ovr=%b, want -8/1/0", $signed(y), y_valid, overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_consume: valid=%b, want 0", y_valid);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (y !== 5'd0 || y_valid !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: y=%b valid=%b ovr=%b, want 00000/0/0", y, y_valid, overrun);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_early: valid=%b after 7 samples, want 0", y_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (y_valid !== 1'b1 || y !== 5'd8) begin
            n_bad++;
            $display("FAIL rst_result: y=%0d valid=%b, want 8/1", $signed(y), y_valid);
        end
    endtask

    initial begin
        test_reset();
        test_plus();
        test_minus_zero();
        test_en_gaps();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stoch_signed_decode.md
# stoch_signed_decode

Converts a signed-channel stochastic bitstream pair (positive channel, negative channel) into a signed binary estimate by counting over fixed, non-overlapping windows of 2^WINDOW_LOG2 samples. Sits directly downstream of the signed stochastic arithmetic stages (e.g. the signed subtractor outputs `y_p`/`y_m`) and hands results to binary logic through a valid/ready output register.

## Interface
- `WINDOW_LOG2`, default 8: window length N = 2^WINDOW_LOG2 samples; legal range 1..16.
- `CLK` in 1: clock, all state on rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `en` in 1: sample enable; the input pair is consumed only in cycles with `en`=1.
- `clear` in 1: synchronous window restart.
- `a_p` in 1: positive-channel stochastic bit.
- `a_m` in 1: negative-channel stochastic bit.
- `y` out WINDOW_LOG2+2: signed two's-complement window sum, range -N..+N; estimate = y/N.
- `y_valid` out 1: `y` holds an unconsumed result.
- `y_ready` in 1: consumer accepts `y` when `y_valid`&&`y_ready`.
- `overrun` out 1: sticky; a completed window overwrote an unconsumed result.

## Operation
- Per-sample contribution d = a_p − a_m ∈ {−1, 0, +1}; (1,1) and (0,0) both give 0.
- Accumulator `acc`, signed WINDOW_LOG2+2 bits; cannot overflow (|acc| ≤ N).
- Sample counter `cnt`, WINDOW_LOG2 bits, increments on each enabled sample and wraps N−1 → 0.
- Enabled sample with cnt < N−1: acc ← acc + d, cnt ← cnt + 1.
- Enabled sample with cnt = N−1 (window end): y ← acc + d, y_valid ← 1, acc ← 0, cnt ← 0. Windows are back-to-back; the next enabled sample belongs to the new window.
- `en`=0: acc, cnt hold; input bits ignored.
- Handshake: y_valid && y_ready clears y_valid next cycle; y holds its value after consumption.
- Window end in the same cycle as a handshake: new result loads, y_valid stays 1, no overrun.
- Window end while y_valid=1 and y_ready=0: y overwritten, y_valid stays 1, overrun ← 1.
- `overrun` clears only on `clear` or reset.
- `clear`=1: acc ← 0, cnt ← 0, overrun ← 0; the current sample is discarded even if `en`=1; y and y_valid are unaffected (a pending result may still be consumed). `clear` has priority over window completion.
- States: COUNTING (implicit, cnt value) × output register {EMPTY, FULL}. EMPTY→FULL on window end; FULL→EMPTY on handshake without a simultaneous window end; FULL→FULL on window end.

## Timing
- Reset values: y = 0, y_valid = 0, overrun = 0, acc = 0, cnt = 0.
- Reset is asserted asynchronously and released synchronously to CLK by the surrounding logic; reset mid-window discards the partial window.
- Latency: y/y_valid update on the clock edge that samples the Nth enabled input; visible the following cycle.
- Throughput: one sample per cycle; one result per N enabled cycles.
- No combinational path from any input to any output.

## Structure
- Shared package `stoch_pkg`: typedef for the ternary contribution (`stoch_diff_t`, signed 2-bit) and a function mapping (p, m) → diff. Reused by other signed-channel blocks.
- One natural sub-module: `stoch_window_counter` (cnt, enable, clear, `last` flag at cnt = N−1). Accumulator and output register stay in the top.

## Test plan
- WINDOW_LOG2=3, en=1, a_p=1, a_m=0 for 8 cycles, y_ready=1 → y=+8, y_valid pulses 1 cycle after 8th sample.
- a_p=0, a_m=1 for 8 cycles → y=−8; then a_p=a_m=1 for 8 cycles → y=0.
- Pattern a_p=1 on samples 0–5, a_m=1 on samples 6–7, en low for 3 cycles mid-window → y=+4, window closes on the 8th enabled sample only.
- y_ready=0 across two full windows (+8 then −2) → y=−2, y_valid=1, overrun=1; clear → overrun=0, y still −2 and valid until y_ready=1.
- Window end coincident with y_ready=1 on a pending result → new value loaded, y_valid stays 1, overrun stays 0.
- nRST asserted after 5 samples, then 8 samples of (1,0) → y=+8 (partial window discarded); all outputs 0 during reset.
